// File: rtl/writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : wb_pkg
//  Description : Shared widths, default sizing constants and the buffered
//                writeback entry type for the writeback arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_pkg;

  localparam int REG_AW             = 5;
  localparam int DATA_W             = 32;
  localparam int FIFO_DEPTH_DEFAULT = 2;
  localparam int STARVE_MAX_DEFAULT = 4;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/writeback_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Small synchronous FIFO holding accepted multi-cycle results
//                until they win the writeback slot.
//  Revision    : 1.0  initial release
//  Ports       : clk, reset_n (async active-low)
//                flush       - empties the FIFO, wins over push/pop
//                push, push_entry - write when not full
//                pop         - advance head when not empty
//                head        - current oldest entry (valid when !empty)
//                full, empty - occupancy flags
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count guards every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Arbitrates the single register-file write port between a
//                single-cycle ALU result and buffered multi-cycle results,
//                with an anti-starvation forced drain and optional busy
//                scoreboard.
//  Revision    : 1.0  initial release
//  Macro       : WB_SCOREBOARD_EN - enables the per-register busy scoreboard
//                (otherwise busy is tied to 0 and issue_* are ignored).
//  Ports       : clk, reset_n (async active-low), flush
//                alu_valid/alu_rd/alu_data in, alu_stall out
//                mem_valid/mem_rd/mem_data in, mem_ready out
//                issue_valid/issue_rd in
//                we3, v_f, a3, wd3 registered writeback outputs
//                busy per-register pending-write bits
// ============================================================================
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_stall,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              we3,
  output logic              v_f,
  output logic [REG_AW-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  output logic [31:0]       busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);

  wb_entry_t         fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              alu_won;

  logic [SW-1:0]     starve_q, starve_d;
  logic              v_f_q,  v_f_d;
  logic              we3_q,  we3_d;
  logic [REG_AW-1:0] a3_q,   a3_d;
  logic [DATA_W-1:0] wd3_q,  wd3_d;

  assign mem_ready = !fifo_full;
  assign fifo_push = mem_valid && !fifo_full && !flush;
  assign alu_stall = (starve_q == STARVE_MAX_C) && !fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .push       (fifo_push),
    .push_entry ('{rd: mem_rd, data: mem_data}),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Source selection: flush > forced drain > ALU > FIFO head > idle.
  always_comb begin
    fifo_pop = 1'b0;
    alu_won  = 1'b0;
    v_f_d    = 1'b0;
    a3_d     = '0;
    wd3_d    = '0;
    starve_d = starve_q;
    if (flush) begin
      starve_d = '0;
    end else begin
      if (alu_stall) begin
        fifo_pop = 1'b1;
      end else if (alu_valid) begin
        alu_won = 1'b1;
        v_f_d   = 1'b1;
        a3_d    = alu_rd;
        wd3_d   = alu_data;
      end else if (!fifo_empty) begin
        fifo_pop = 1'b1;
      end
      if (fifo_pop) begin
        v_f_d = 1'b1;
        a3_d  = fifo_head.rd;
        wd3_d = fifo_head.data;
      end
      if (fifo_pop || fifo_empty) begin
        starve_d = '0;
      end else if (alu_won && (starve_q != STARVE_MAX_C)) begin
        starve_d = starve_q + 1'b1;
      end
    end
    // r0 results are consumed but never written.
    we3_d = v_f_d && (a3_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
      v_f_q    <= 1'b0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      starve_q <= starve_d;
      v_f_q    <= v_f_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign v_f = v_f_q;
  assign we3 = we3_q;
  assign a3  = a3_q;
  assign wd3 = wd3_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Clear on the selected write first so a same-edge issue to that rd wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (v_f_d) busy_d[a3_d] = 1'b0;
      if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd};
  assign busy         = '0;
`endif

endmodule : writeback_arbiter
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_arbiter
//  Description : Self-checking bench for writeback_arbiter: a directed vector
//                table, hand-written flush/reset/scoreboard sequences and a
//                randomized phase against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush, alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_rd, mem_rd, issue_rd;
  logic [31:0] alu_data, mem_data;
  logic        alu_stall, mem_ready, we3, v_f;
  logic [4:0]  a3;
  logic [31:0] wd3, busy;

  writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .we3(we3), .v_f(v_f), .a3(a3), .wd3(wd3), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        flush;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_v;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        iss_v;
    logic [4:0]  iss_rd;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic        er;   // expected mem_ready before the edge
    logic        es;   // expected alu_stall before the edge
    logic        ev;   // expected v_f after the edge
    logic        ew;   // expected we3 after the edge
    logic [4:0]  ea;
    logic [31:0] ed;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  ent_t        mq[$];
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_vf, m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;

  function automatic logic m_ready();
    return mq.size() < DEPTH;
  endfunction

  function automatic logic m_stall();
    return (m_starve == SMAX) && (mq.size() > 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_starve = 0; m_busy = '0;
    m_vf = 0; m_we = 0; m_a3 = '0; m_wd = '0;
  endtask

  task automatic model_edge(input in_t v);
    logic ready, stall, took_head, alu_won;
    int   pre;
    ent_t e;
    ready = m_ready(); stall = m_stall(); pre = mq.size();
    took_head = 0; alu_won = 0;
    if (v.flush) begin
      mq.delete();
      m_starve = 0; m_busy = '0; m_vf = 0; m_we = 0;
      return;
    end
    if (stall || (!v.alu_v && pre > 0)) begin
      e = mq.pop_front();
      took_head = 1;
      m_vf = 1; m_a3 = e.rd; m_wd = e.data;
    end else if (v.alu_v) begin
      alu_won = 1;
      m_vf = 1; m_a3 = v.alu_rd; m_wd = v.alu_data;
    end else begin
      m_vf = 0;
    end
    m_we = m_vf && (m_a3 != 0);
    if (took_head || pre == 0) m_starve = 0;
    else if (alu_won)          m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
    if (v.mem_v && ready) mq.push_back('{rd: v.mem_rd, data: v.mem_data});
`ifdef WB_SCOREBOARD_EN
    if (m_vf) m_busy[m_a3] = 1'b0;
    if (v.iss_v && v.iss_rd != 0) m_busy[v.iss_rd] = 1'b1;
`endif
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic in_t mi(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                             input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    in_t r = '0;
    r.alu_v = av; r.alu_rd = ard; r.alu_data = ad;
    r.mem_v = mv; r.mem_rd = mrd; r.mem_data = md;
    return r;
  endfunction

  function automatic vec_t mvec(input in_t i, input logic er, input logic es, input logic ev,
                                input logic ew, input logic [4:0] ea, input logic [31:0] ed);
    vec_t r;
    r.in = i; r.er = er; r.es = es; r.ev = ev; r.ew = ew; r.ea = ea; r.ed = ed;
    return r;
  endfunction

  task automatic drive(input in_t v);
    flush = v.flush; alu_valid = v.alu_v; alu_rd = v.alu_rd; alu_data = v.alu_data;
    mem_valid = v.mem_v; mem_rd = v.mem_rd; mem_data = v.mem_data;
    issue_valid = v.iss_v; issue_rd = v.iss_rd;
  endtask

  // Starts and ends at a falling edge.
  task automatic cycle(input in_t v, input vec_t e, input logic use_e);
    drive(v);
    #1;
    check("mem_ready", mem_ready, m_ready());
    check("alu_stall", alu_stall, m_stall());
    if (use_e) begin
      check("tbl_mem_ready", mem_ready, e.er);
      check("tbl_alu_stall", alu_stall, e.es);
    end
    @(posedge clk);
    model_edge(v);
    #1;
    check("v_f", v_f, m_vf);
    check("we3", we3, m_we);
    if (m_vf) begin
      check("a3", a3, m_a3);
      check("wd3", wd3, m_wd);
    end
    check("busy", busy, m_busy);
    if (use_e) begin
      check("tbl_v_f", v_f, e.ev);
      check("tbl_we3", we3, e.ew);
      if (e.ev) begin
        check("tbl_a3", a3, e.ea);
        check("tbl_wd3", wd3, e.ed);
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input in_t v);
    cycle(v, '0, 1'b0);
  endtask

  vec_t tbl[14];

  initial begin
    in_t v;
    reset_n = 0;
    drive('0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_v_f", v_f, 0);
    check("rst_we3", we3, 0);
    check("rst_a3", a3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_alu_stall", alu_stall, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1;

    // ---- directed table: ALU write, mem to r0, backpressure and forced drain ----
    tbl[0]  = mvec(mi(1, 5'd5, 32'hDEADBEEF, 0, 0, 0),        1, 0, 1, 1, 5'd5,  32'hDEADBEEF);
    tbl[1]  = mvec(mi(0, 0, 0, 1, 5'd0, 32'h1234),            1, 0, 0, 0, 5'd0,  32'h0);
    tbl[2]  = mvec(mi(0, 0, 0, 0, 0, 0),                      1, 0, 1, 0, 5'd0,  32'h1234);
    tbl[3]  = mvec(mi(0, 0, 0, 0, 0, 0),                      1, 0, 0, 0, 5'd0,  32'h0);
    tbl[4]  = mvec(mi(1, 5'd10, 32'hA0, 1, 5'd20, 32'h100),   1, 0, 1, 1, 5'd10, 32'hA0);
    tbl[5]  = mvec(mi(1, 5'd11, 32'hA1, 1, 5'd21, 32'h101),   1, 0, 1, 1, 5'd11, 32'hA1);
    tbl[6]  = mvec(mi(1, 5'd12, 32'hA2, 1, 5'd22, 32'h102),   0, 0, 1, 1, 5'd12, 32'hA2);
    tbl[7]  = mvec(mi(1, 5'd13, 32'hA3, 1, 5'd22, 32'h102),   0, 0, 1, 1, 5'd13, 32'hA3);
    tbl[8]  = mvec(mi(1, 5'd14, 32'hA4, 1, 5'd22, 32'h102),   0, 0, 1, 1, 5'd14, 32'hA4);
    tbl[9]  = mvec(mi(1, 5'd15, 32'hA5, 1, 5'd22, 32'h102),   0, 1, 1, 1, 5'd20, 32'h100);
    tbl[10] = mvec(mi(1, 5'd16, 32'hA6, 1, 5'd22, 32'h102),   1, 0, 1, 1, 5'd16, 32'hA6);
    tbl[11] = mvec(mi(0, 0, 0, 0, 0, 0),                      0, 0, 1, 1, 5'd21, 32'h101);
    tbl[12] = mvec(mi(0, 0, 0, 0, 0, 0),                      1, 0, 1, 1, 5'd22, 32'h102);
    tbl[13] = mvec(mi(0, 0, 0, 0, 0, 0),                      1, 0, 0, 0, 5'd0,  32'h0);
    for (int i = 0; i < 14; i++) cycle(tbl[i].in, tbl[i], 1'b1);

    // ---- scoreboard: set, same-edge set vs clear, later clear ----
    v = '0; v.iss_v = 1; v.iss_rd = 5'd7;
    cyc(v);
`ifdef WB_SCOREBOARD_EN
    check("sb_set7", busy[7], 1);
`else
    check("sb_off", busy, 0);
`endif
    v = mi(1, 5'd7, 32'h77, 0, 0, 0); v.iss_v = 1; v.iss_rd = 5'd7;
    cyc(v);
`ifdef WB_SCOREBOARD_EN
    check("sb_set_wins", busy[7], 1);
`endif
    cyc(mi(1, 5'd7, 32'h78, 0, 0, 0));
    check("sb_clear7", busy[7], 0);

    // ---- flush with two buffered entries ----
    v = mi(1, 5'd1, 32'h11, 1, 5'd3, 32'h33); v.iss_v = 1; v.iss_rd = 5'd7;
    cyc(v);
    cyc(mi(1, 5'd2, 32'h22, 1, 5'd4, 32'h44));
    check("pre_flush_full", mem_ready, 0);
    v = mi(1, 5'd9, 32'h99, 1, 5'd6, 32'h66); v.flush = 1;
    cyc(v);
    check("flush_we3", we3, 0);
    check("flush_v_f", v_f, 0);
    check("flush_busy", busy, 0);
    check("flush_mem_ready", mem_ready, 1);
    cyc('0);
    check("flush_empty_idle", v_f, 0);

    // ---- async reset in the middle of a drain ----
    cyc(mi(1, 5'd1, 32'h11, 1, 5'd3, 32'h33));
    cyc(mi(1, 5'd2, 32'h22, 1, 5'd4, 32'h44));
    cyc('0);
    check("drain_first_a3", a3, 3);
    #2;
    reset_n = 0;
    #1;
    check("arst_we3", we3, 0);
    check("arst_v_f", v_f, 0);
    check("arst_a3", a3, 0);
    check("arst_wd3", wd3, 0);
    check("arst_mem_ready", mem_ready, 1);
    check("arst_alu_stall", alu_stall, 0);
    check("arst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc('0);
      check("post_rst_no_write", we3, 0);
    end

    // ---- randomized phase against the model ----
    for (int i = 0; i < 400; i++) begin
      v = '0;
      v.flush    = ($urandom_range(0, 19) == 0);
      v.alu_v    = ($urandom_range(0, 2) != 0);
      v.alu_rd   = 5'($urandom_range(0, 31));
      v.alu_data = $urandom;
      v.mem_v    = ($urandom_range(0, 1) != 0);
      v.mem_rd   = 5'($urandom_range(0, 31));
      v.mem_data = $urandom;
      v.iss_v    = ($urandom_range(0, 1) != 0);
      v.iss_rd   = 5'($urandom_range(0, 31));
      cyc(v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_writeback_arbiter
`default_nettype wire
